pll_lock_ctrl: RTL and testbench

Reset and lock sequencer for the core PLL. It runs on the free-running reference clock, pulses the PLL's active-high reset, waits for `locked` to rise and stay stable, and only then releases the downstream system reset. It also detects lock loss and timeouts, re-sequences automatically, and reports the result as status signals.

---
 rtl/pll_lock_ctrl_pkg.sv | 19 +
 rtl/pll_lock_ctrl_if.sv | 22 ++
 rtl/sync_bit.sv | 21 ++
 rtl/pll_lock_ctrl.sv | 106 ++++++++++
 tb/tb_pll_lock_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// rtl/pll_lock_ctrl_pkg.sv - shared types and constants for the PLL lock sequencer
package pll_lock_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int RELOCK_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// rtl/pll_lock_ctrl_if.sv - control and status bundle between the sequencer and its user
interface pll_lock_ctrl_if;
    import pll_lock_ctrl_pkg::*;

    logic                soft_reset;
    logic                pll_locked;
    logic                pll_rst;
    logic                sys_rst_n;
    logic                ready;
    logic [RELOCK_W-1:0] relock_count;
    logic                timeout_err;

    modport master (
        output soft_reset, pll_locked,
        input  pll_rst, sys_rst_n, ready, relock_count, timeout_err
    );

    modport slave (
        input  soft_reset, pll_locked,
        output pll_rst, sys_rst_n, ready, relock_count, timeout_err
    );
endinterface

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop single-bit synchronizer with async active-low reset
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - pulses PLL reset, qualifies lock, releases system reset, re-sequences on loss
module pll_lock_ctrl
    import pll_lock_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int SYNC_STAGES         = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pll_lock_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                       LOCK_TIMEOUT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_clr;
    logic                relock_inc;
    logic                timeout_set;
    logic                locked_s;
    logic [RELOCK_W-1:0] relock_count_q;
    logic                timeout_err_q;
    logic                pll_rst_q, sys_rst_n_q, ready_q;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_PLL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_clr ? '0 : cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        relock_inc  = 1'b0;
        timeout_set = 1'b0;
        unique case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = RESET_PLL;
                    relock_inc  = 1'b1;
                    timeout_set = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s)               state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt  = RESET_PLL;
                    relock_inc = 1'b1;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase
        // A soft restart is not an automatic re-sequence, except when it coincides with lock loss in RUN.
        if (bus.soft_reset) begin
            state_nxt   = RESET_PLL;
            timeout_set = 1'b0;
            if (!(state == RUN && !locked_s)) relock_inc = 1'b0;
        end
        cnt_clr = bus.soft_reset || (state_nxt != state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q      <= 1'b1;
            sys_rst_n_q    <= 1'b0;
            ready_q        <= 1'b0;
            relock_count_q <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            pll_rst_q   <= (state_nxt == RESET_PLL);
            sys_rst_n_q <= (state_nxt == RUN);
            ready_q     <= (state_nxt == RUN);
            if (relock_inc && (relock_count_q != '1)) relock_count_q <= relock_count_q + RELOCK_W'(1);
            if (timeout_set) timeout_err_q <= 1'b1;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst_n    = sys_rst_n_q;
    assign bus.ready        = ready_q;
    assign bus.relock_count = relock_count_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - directed self-checking bench for pll_lock_ctrl
module tb_pll_lock_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pll_lock_ctrl_if bus();

    pll_lock_ctrl #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .SYNC_STAGES         (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            step(1);
            if (bus.ready === 1'b1) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    task automatic check_outs(input string tag, input logic prst, input logic rdy,
                              input logic [7:0] rc, input logic te);
        check({tag, "_pll_rst"}, bus.pll_rst, prst);
        check({tag, "_sys_rst_n"}, bus.sys_rst_n, rdy);
        check({tag, "_ready"}, bus.ready, rdy);
        check({tag, "_relock"}, bus.relock_count, rc);
        check({tag, "_timeout"}, bus.timeout_err, te);
    endtask

    initial begin
        bus.soft_reset = 1'b0;
        bus.pll_locked = 1'b0;
        step(3);
        check_outs("reset", 1'b1, 1'b0, 8'd0, 1'b0);

        // Normal bring-up: release, pll_rst high for 4 edges, lock 10 cycles after release.
        rst_n = 1'b1;
        step(3);
        check("bringup_rst_held", bus.pll_rst, 1'b1);
        step(1);
        check("bringup_rst_drop", bus.pll_rst, 1'b0);
        step(6);
        bus.pll_locked = 1'b1;
        step(10);
        check("bringup_ready_early", bus.ready, 1'b0);
        step(1);
        check_outs("bringup_run", 1'b0, 1'b1, 8'd0, 1'b0);

        // Soft reset in RUN, then glitch lock at stable count 5.
        bus.soft_reset = 1'b1;
        step(1);
        bus.soft_reset = 1'b0;
        check_outs("soft_run", 1'b1, 1'b0, 8'd0, 1'b0);
        step(5);
        check("glitch_in_stable_prst", bus.pll_rst, 1'b0);
        step(3);
        bus.pll_locked = 1'b0;
        step(1);
        bus.pll_locked = 1'b1;
        step(1);
        for (int i = 0; i < 9; i++) begin
            step(1);
            check("glitch_prst_low", bus.pll_rst, 1'b0);
            check("glitch_ready_low", bus.ready, 1'b0);
        end
        step(1);
        check("glitch_ready_rise", bus.ready, 1'b1);

        // Lock loss in RUN.
        bus.pll_locked = 1'b0;
        step(2);
        check("loss_ready_still", bus.ready, 1'b1);
        step(1);
        check_outs("loss_drop", 1'b1, 1'b0, 8'd1, 1'b0);
        bus.pll_locked = 1'b1;
        wait_ready("loss_recover", 40);
        check("loss_recover_relock", bus.relock_count, 32'd1);

        // Soft reset coinciding with lock loss counts as lock loss.
        bus.pll_locked = 1'b0;
        step(2);
        bus.soft_reset = 1'b1;
        step(1);
        bus.soft_reset = 1'b0;
        check_outs("soft_loss", 1'b1, 1'b0, 8'd2, 1'b0);
        bus.pll_locked = 1'b1;
        wait_ready("soft_loss_recover", 40);

        // Async reset while in STABLE.
        bus.soft_reset = 1'b1;
        step(1);
        bus.soft_reset = 1'b0;
        step(7);
        check("pre_async_prst", bus.pll_rst, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs("async", 1'b1, 1'b0, 8'd0, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(3);
        check("async_rel_rst_held", bus.pll_rst, 1'b1);
        step(1);
        check("async_rel_rst_drop", bus.pll_rst, 1'b0);
        step(8);
        check("async_rel_ready_early", bus.ready, 1'b0);
        step(1);
        check("async_rel_ready", bus.ready, 1'b1);

        // Timeout with no lock.
        bus.pll_locked = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(35);
        check_outs("to_before", 1'b0, 1'b0, 8'd0, 1'b0);
        step(1);
        check_outs("to_first", 1'b1, 1'b0, 8'd1, 1'b1);
        step(4);
        check("to_repulse_end", bus.pll_rst, 1'b0);
        step(32);
        check_outs("to_second", 1'b1, 1'b0, 8'd2, 1'b1);
        step(36 * 253);
        check("to_255", bus.relock_count, 32'd255);
        step(36 * 45);
        check_outs("to_300", 1'b1, 1'b0, 8'd255, 1'b1);
        bus.soft_reset = 1'b1;
        step(1);
        bus.soft_reset = 1'b0;
        check_outs("to_soft", 1'b1, 1'b0, 8'd255, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
